watch_alarm: RTL and testbench

WATCH_ALARM -- requirements
Module: watch_alarm

---
 rtl/watch_alarm.sv | 149 ++++++++++++++
 tb/tb_watch_alarm.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/watch_alarm.sv
// rtl/watch_alarm.sv - time-of-day counter with loadable alarm and timed ring output
module watch_alarm #(
    parameter int HOUR_MOD  = 24,
    parameter int ALARM_SEC = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic [4:0] hour_in,
    input  logic [5:0] min_in,
    input  logic [5:0] sec_in,
    input  logic       pm_in,
    input  logic       ci,
    output logic       co,
    output logic [4:0] hour_out,
    output logic [5:0] min_out,
    output logic [5:0] sec_out,
    output logic       pm_out,
    input  logic       al_ld,
    input  logic [4:0] al_hour_in,
    input  logic [5:0] al_min_in,
    input  logic       al_pm_in,
    input  logic       al_en,
    input  logic       al_stop,
    output logic       alarm,
    output logic [4:0] al_hour_out,
    output logic [5:0] al_min_out,
    output logic       al_pm_out
);
    localparam bit         IS12     = (HOUR_MOD == 12);
    localparam logic [4:0] HOUR_RST = IS12 ? 5'd12 : 5'd0;
    localparam logic [7:0] AL_LOAD  = 8'(ALARM_SEC);

    typedef enum logic {IDLE, RING} state_t;

    logic [4:0] hour_q, hour_d, al_hour_q, al_hour_d;
    logic [5:0] min_q, min_d, sec_q, sec_d, al_min_q, al_min_d;
    logic       pm_q, pm_d, al_pm_q, al_pm_d;
    logic [7:0] cnt_q, cnt_d;
    state_t     state_q, state_d;
    logic       cnt_ev, match;

    function automatic logic [4:0] san_hour(input logic [4:0] h);
        if (IS12) return ((h == 5'd0) || (h > 5'd12)) ? 5'd12 : h;
        return (h > 5'd23) ? 5'd0 : h;
    endfunction

    function automatic logic [5:0] san_ms(input logic [5:0] v);
        return (v > 6'd59) ? 6'd0 : v;
    endfunction

    assign cnt_ev = ci & ~ld;

    always_comb begin
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        pm_d   = pm_q;
        if (ld) begin
            sec_d  = san_ms(sec_in);
            min_d  = san_ms(min_in);
            hour_d = san_hour(hour_in);
            pm_d   = IS12 ? pm_in : 1'b0;
        end else if (ci) begin
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d = 6'd0;
                    if (IS12) begin
                        hour_d = (hour_q == 5'd12) ? 5'd1 : hour_q + 5'd1;
                        if (hour_q == 5'd11) pm_d = ~pm_q;
                    end else begin
                        hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                    end
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
    end

    always_comb begin
        al_hour_d = al_hour_q;
        al_min_d  = al_min_q;
        al_pm_d   = al_pm_q;
        if (al_ld) begin
            al_hour_d = san_hour(al_hour_in);
            al_min_d  = san_ms(al_min_in);
            al_pm_d   = IS12 ? al_pm_in : 1'b0;
        end
    end

    // Only a counted second can hit the alarm; loading the same time never rings.
    assign match = cnt_ev && al_en && (hour_d == al_hour_q) && (min_d == al_min_q)
                   && (sec_d == 6'd0) && (!IS12 || (pm_d == al_pm_q));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!al_en || al_stop) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
        end else if (match) begin
            state_d = RING;
            cnt_d   = AL_LOAD;
        end else if ((state_q == RING) && cnt_ev) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q <= 8'd1) state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hour_q    <= HOUR_RST;
            min_q     <= 6'd0;
            sec_q     <= 6'd0;
            pm_q      <= 1'b0;
            al_hour_q <= HOUR_RST;
            al_min_q  <= 6'd0;
            al_pm_q   <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
        end else begin
            hour_q    <= hour_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            pm_q      <= pm_d;
            al_hour_q <= al_hour_d;
            al_min_q  <= al_min_d;
            al_pm_q   <= al_pm_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
        end
    end

    assign co = cnt_ev & ~rst & (sec_q == 6'd59) & (min_q == 6'd59)
                & (IS12 ? ((hour_q == 5'd11) & pm_q) : (hour_q == 5'd23));

    assign hour_out    = hour_q;
    assign min_out     = min_q;
    assign sec_out     = sec_q;
    assign pm_out      = IS12 ? pm_q : (hour_q >= 5'd12);
    assign al_hour_out = al_hour_q;
    assign al_min_out  = al_min_q;
    assign al_pm_out   = IS12 ? al_pm_q : (al_hour_q >= 5'd12);
    assign alarm       = (state_q == RING);
endmodule

// File: tb/tb_watch_alarm.sv
// tb/tb_watch_alarm.sv - directed checks of 24-hour and 12-hour watch_alarm instances
module tb_watch_alarm;
    logic       clk = 1'b0;
    logic       rst, ld, pm_in, ci, al_ld, al_pm_in, al_en, al_stop;
    logic [4:0] hour_in, al_hour_in;
    logic [5:0] min_in, sec_in, al_min_in;

    logic       co24, pm24, alarm24, alpm24;
    logic [4:0] hour24, alhour24;
    logic [5:0] min24, sec24, almin24;
    logic       co12, pm12, alarm12, alpm12;
    logic [4:0] hour12, alhour12;
    logic [5:0] min12, sec12, almin12;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    watch_alarm #(.HOUR_MOD(24), .ALARM_SEC(3)) u24 (
        .clk(clk), .rst(rst), .ld(ld), .hour_in(hour_in), .min_in(min_in),
        .sec_in(sec_in), .pm_in(pm_in), .ci(ci), .co(co24), .hour_out(hour24),
        .min_out(min24), .sec_out(sec24), .pm_out(pm24), .al_ld(al_ld),
        .al_hour_in(al_hour_in), .al_min_in(al_min_in), .al_pm_in(al_pm_in),
        .al_en(al_en), .al_stop(al_stop), .alarm(alarm24), .al_hour_out(alhour24),
        .al_min_out(almin24), .al_pm_out(alpm24)
    );

    watch_alarm #(.HOUR_MOD(12), .ALARM_SEC(3)) u12 (
        .clk(clk), .rst(rst), .ld(ld), .hour_in(hour_in), .min_in(min_in),
        .sec_in(sec_in), .pm_in(pm_in), .ci(ci), .co(co12), .hour_out(hour12),
        .min_out(min12), .sec_out(sec12), .pm_out(pm12), .al_ld(al_ld),
        .al_hour_in(al_hour_in), .al_min_in(al_min_in), .al_pm_in(al_pm_in),
        .al_en(al_en), .al_stop(al_stop), .alarm(alarm12), .al_hour_out(alhour12),
        .al_min_out(almin12), .al_pm_out(alpm12)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] hms(input int h, input int m, input int s);
        return 32'((h << 12) | (m << 6) | s);
    endfunction

    function automatic logic [31:0] t24();
        return {15'd0, hour24, min24, sec24};
    endfunction

    function automatic logic [31:0] t12();
        return {15'd0, hour12, min12, sec12};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int h, input int m, input int s, input logic p);
        hour_in = 5'(h); min_in = 6'(m); sec_in = 6'(s); pm_in = p;
        ld = 1'b1; ci = 1'b0;
        step();
        ld = 1'b0;
    endtask

    task automatic set_alarm(input int h, input int m, input logic p);
        al_hour_in = 5'(h); al_min_in = 6'(m); al_pm_in = p;
        al_ld = 1'b1;
        step();
        al_ld = 1'b0;
    endtask

    task automatic tick();
        ci = 1'b1;
        step();
        ci = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ld = 1'b0; ci = 1'b1; pm_in = 1'b0;
        hour_in = 5'd23; min_in = 6'd59; sec_in = 6'd59;
        al_ld = 1'b0; al_hour_in = 5'd0; al_min_in = 6'd0; al_pm_in = 1'b0;
        al_en = 1'b0; al_stop = 1'b0;
        #2;
        check("co_in_reset", {31'd0, co24}, 32'd0);
        step(); step();
        rst = 1'b0; ci = 1'b0;
        check("rst_time24", t24(), hms(0, 0, 0));
        check("rst_time12", t12(), hms(12, 0, 0));
        check("rst_pm12", {31'd0, pm12}, 32'd0);
        check("rst_al12", {26'd0, alhour12, almin12}, {26'd0, 5'd12, 6'd0});
        check("rst_alarm", {30'd0, alarm24, alarm12}, 32'd0);

        // Plain counting across a minute boundary
        load(11, 20, 57, 1'b0);
        check("ld_11_20_57", t24(), hms(11, 20, 57));
        ci = 1'b1;
        step(); check("cnt_58", t24(), hms(11, 20, 58));
        step(); check("cnt_59", t24(), hms(11, 20, 59));
        #1; check("co_mid_day", {31'd0, co24}, 32'd0);
        step(); check("cnt_min", t24(), hms(11, 21, 0));
        step(); check("cnt_01", t24(), hms(11, 21, 1));
        ci = 1'b0;

        // Day wrap in 24-hour mode
        load(23, 59, 57, 1'b0);
        check("pm24_comb", {31'd0, pm24}, 32'd1);
        ci = 1'b1;
        step(); check("wrap_58", t24(), hms(23, 59, 58));
        step(); check("wrap_59", t24(), hms(23, 59, 59));
        #1; check("co_last_sec", {31'd0, co24}, 32'd1);
        step(); check("wrap_00", t24(), hms(0, 0, 0));
        check("co_after_wrap", {31'd0, co24}, 32'd0);
        step(); check("wrap_01", t24(), hms(0, 0, 1));
        ci = 1'b0;

        // ld beats ci; out-of-range fields sanitised
        load(23, 59, 59, 1'b0);
        ld = 1'b1; ci = 1'b1; #1;
        check("co_with_ld", {31'd0, co24}, 32'd0);
        step(); ld = 1'b0; ci = 1'b0;
        check("ld_over_ci", t24(), hms(23, 59, 59));
        load(30, 61, 62, 1'b0);
        check("san24", t24(), hms(0, 0, 0));
        check("san12", t12(), hms(12, 0, 0));
        load(0, 5, 6, 1'b0);
        check("san12_h0", t12(), hms(12, 5, 6));

        // 12-hour mode: noon, 12->1, midnight
        load(11, 59, 59, 1'b0);
        ci = 1'b1; #1;
        check("co12_am", {31'd0, co12}, 32'd0);
        step(); ci = 1'b0;
        check("noon_t", t12(), hms(12, 0, 0));
        check("noon_pm", {31'd0, pm12}, 32'd1);
        load(12, 59, 59, 1'b1);
        tick();
        check("one_pm_t", t12(), hms(1, 0, 0));
        check("one_pm_pm", {31'd0, pm12}, 32'd1);
        load(11, 59, 59, 1'b1);
        ci = 1'b1; #1;
        check("co12_pm", {31'd0, co12}, 32'd1);
        step(); ci = 1'b0;
        check("midnight_t", t12(), hms(12, 0, 0));
        check("midnight_pm", {31'd0, pm12}, 32'd0);

        // Alarm: ring for three counted seconds
        set_alarm(7, 30, 1'b0);
        check("al_stored", {26'd0, alhour24, almin24}, {26'd0, 5'd7, 6'd30});
        check("al_pm12", {31'd0, alpm12}, 32'd0);
        al_en = 1'b1;
        load(7, 29, 59, 1'b0);
        check("no_ring_pre", {30'd0, alarm24, alarm12}, 32'd0);
        tick();
        check("ring_start", {30'd0, alarm24, alarm12}, 32'd3);
        tick(); check("ring_c2", {31'd0, alarm24}, 32'd1);
        tick(); check("ring_c1", {31'd0, alarm24}, 32'd1);
        tick(); check("ring_end", {30'd0, alarm24, alarm12}, 32'd0);

        // Stop, then load straight onto the alarm time
        load(7, 29, 59, 1'b0);
        tick();
        check("ring2", {31'd0, alarm24}, 32'd1);
        al_stop = 1'b1; step(); al_stop = 1'b0;
        check("stopped", {31'd0, alarm24}, 32'd0);
        load(7, 30, 0, 1'b0);
        check("ld_no_ring", {31'd0, alarm24}, 32'd0);
        step();
        check("ld_no_ring2", {31'd0, alarm24}, 32'd0);

        // Changing alarm time keeps ringing; disarm clears
        load(7, 29, 59, 1'b0);
        tick();
        set_alarm(8, 0, 1'b0);
        check("al_ld_ringing", {31'd0, alarm24}, 32'd1);
        al_en = 1'b0; step();
        check("disarm", {31'd0, alarm24}, 32'd0);

        // Stop in the same cycle as a match wins; alarm fields sanitised
        set_alarm(7, 30, 1'b0);
        al_en = 1'b1;
        load(7, 29, 59, 1'b0);
        al_stop = 1'b1; tick(); al_stop = 1'b0;
        check("stop_vs_match", {31'd0, alarm24}, 32'd0);

        // Reset mid-ring
        load(7, 29, 59, 1'b0);
        tick();
        check("ring3", {31'd0, alarm24}, 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        check("rst_ring", {30'd0, alarm24, alarm12}, 32'd0);

        set_alarm(25, 60, 1'b1);
        check("al_san24", {26'd0, alhour24, almin24}, 32'd0);
        check("al_san12", {26'd0, alhour12, almin12}, {26'd0, 5'd12, 6'd0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
